sys: RTL and testbench

- Monitor-core system block: SPI slave through which an external MCU queries core identity, sets `core_config`, controls a simple overlay, reads joypads and streams ROM bytes into the core.
- All logic runs in a single `clk` domain; SPI pins are oversampled.
- Sits between the board MCU SPI pins and the emulator core / video mixer.

---
 rtl/sys_pkg.sv | 42 ++++
 rtl/sys_if.sv | 18 +
 rtl/spi_slave_byte.sv | 68 ++++++
 rtl/sys.sv | 194 +++++++++++++++++++
 tb/tb_sys.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sys_pkg.sv
// sys shared definitions: SPI command codes, identity bytes, RX states.
// Imported by the monitor-core system block.
package sys_pkg;

  localparam logic [7:0] CMD_ID      = 8'd1;
  localparam logic [7:0] CMD_CFG     = 8'd2;
  localparam logic [7:0] CMD_OVL     = 8'd3;
  localparam logic [7:0] CMD_COLOR   = 8'd4;
  localparam logic [7:0] CMD_JOY     = 8'd5;
  localparam logic [7:0] CMD_LOADING = 8'd6;
  localparam logic [7:0] CMD_ROM     = 8'd7;

  localparam logic [7:0] ID_M   = 8'h4D;
  localparam logic [7:0] ID_C   = 8'h43;
  localparam logic [7:0] ID_END = 8'h00;

  typedef enum logic [1:0] {
    ST_CMD,
    ST_ARGS,
    ST_DATA,
    ST_DONE
  } rx_state_t;

  // index of the final argument byte
  function automatic logic [1:0] arg_last(
    input logic [7:0] c
  );
    case (c)
      CMD_CFG:   return 2'd3;
      CMD_COLOR: return 2'd1;
      CMD_ROM:   return 2'd2;
      default:   return 2'd0;
    endcase
  endfunction

  function automatic logic [7:0] id_digit(
    input int id
  );
    return 8'(32'h30 + id);
  endfunction

endpackage

// File: rtl/sys_if.sv
// SPI pin bundle between the board MCU and the sys block.
// The MCU side is the master.
interface sys_if;
  logic cs;
  logic sclk;
  logic mosi;
  logic miso;

  modport master (
    output cs, sclk, mosi,
    input  miso
  );

  modport slave (
    input  cs, sclk, mosi,
    output miso
  );
endinterface

// File: rtl/spi_slave_byte.sv
// Oversampled SPI mode-0 slave: synchronizers, byte RX shift,
// TX shift with preload while CS is high.
module spi_slave_byte (
  input  logic       clk,
  input  logic       rst_n,
  sys_if.slave       spi,
  input  logic [7:0] tx_byte,
  output logic [7:0] byte_rx,
  output logic       byte_valid,
  output logic       cs_high,
  output logic       tx_done
);

  logic [1:0] cs_s;
  logic [1:0] sck_s;
  logic [1:0] mosi_s;
  logic       sck_d;
  logic       cs_d;
  logic [2:0] bit_cnt;
  logic [6:0] sr;
  logic [7:0] txreg;
  logic       got8;
  logic       rise;

  assign cs_high  = cs_s[1];
  assign rise     = sck_s[1] & ~sck_d & ~cs_s[1];
  assign spi.miso = txreg[7];
  // pops only on a CS rise ending a full-byte read
  assign tx_done  = cs_s[1] & ~cs_d & got8;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s       <= 2'b11;
      sck_s      <= 2'b00;
      mosi_s     <= 2'b00;
      sck_d      <= 1'b0;
      cs_d       <= 1'b1;
      bit_cnt    <= 3'd0;
      sr         <= 7'd0;
      txreg      <= 8'd0;
      got8       <= 1'b0;
      byte_rx    <= 8'd0;
      byte_valid <= 1'b0;
    end else begin
      cs_s       <= {cs_s[0], spi.cs};
      sck_s      <= {sck_s[0], spi.sclk};
      mosi_s     <= {mosi_s[0], spi.mosi};
      sck_d      <= sck_s[1];
      cs_d       <= cs_s[1];
      byte_valid <= 1'b0;
      if (cs_s[1]) begin
        bit_cnt <= 3'd0;
        got8    <= 1'b0;
        txreg   <= tx_byte;
      end else if (rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        sr      <= {sr[5:0], mosi_s[1]};
        txreg   <= {txreg[6:0], 1'b0};
        if (bit_cnt == 3'd7) begin
          byte_rx    <= {sr, mosi_s[1]};
          byte_valid <= 1'b1;
          got8       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sys.sv
// Monitor-core system block: SPI command decode, response queue,
// core config, overlay and ROM byte streaming.
module sys
  import sys_pkg::*;
#(
  parameter int FREQ    = 21_477_000,
  parameter int CORE_ID = 1
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        overlay,
  input  logic [8:0]  overlay_x,
  input  logic [7:0]  overlay_y,
  output logic [14:0] overlay_color,
  input  logic [11:0] joy1,
  input  logic [11:0] joy2,
  output logic        rom_loading,
  output logic [7:0]  rom_do,
  output logic        rom_do_valid,
  output logic [31:0] core_config,
  input  logic        sspi_cs,
  input  logic        sspi_clk,
  input  logic        sspi_mosi,
  output logic        sspi_miso
);

  localparam int TMO = FREQ / 100;
  localparam int TW  = $clog2(TMO + 1);

  sys_if spi_pins ();

  assign spi_pins.cs   = sspi_cs;
  assign spi_pins.sclk = sspi_clk;
  assign spi_pins.mosi = sspi_mosi;
  assign sspi_miso     = spi_pins.miso;

  logic [7:0]  byte_rx;
  logic        byte_valid;
  logic        cs_high;
  logic        tx_done;
  logic [7:0]  head;

  spi_slave_byte u_spi (
    .clk        (clk),
    .rst_n      (resetn),
    .spi        (spi_pins.slave),
    .tx_byte    (head),
    .byte_rx    (byte_rx),
    .byte_valid (byte_valid),
    .cs_high    (cs_high),
    .tx_done    (tx_done)
  );

  rx_state_t   state;
  rx_state_t   state_n;
  logic [7:0]  cmd;
  logic [1:0]  arg_cnt;
  logic [23:0] args;
  logic [23:0] len;
  logic [23:0] len_full;
  logic        last_arg;
  logic        commit;
  logic        rom_stb;
  logic [14:0] color;

  assign last_arg = arg_cnt == arg_last(cmd);
  assign len_full = {args[15:0], byte_rx};

  always_comb begin
    state_n = state;
    commit  = 1'b0;
    rom_stb = 1'b0;
    if (cs_high) begin
      state_n = ST_CMD;
    end else if (byte_valid) begin
      unique case (state)
        ST_CMD: state_n = ST_ARGS;
        ST_ARGS: begin
          if (last_arg) begin
            commit  = 1'b1;
            state_n = (cmd == CMD_ROM && len_full != 24'd0)
                    ? ST_DATA : ST_DONE;
          end
        end
        ST_DATA: begin
          rom_stb = 1'b1;
          if (len == 24'd1) state_n = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_CMD;
      cmd     <= 8'd0;
      arg_cnt <= 2'd0;
      args    <= 24'd0;
      len     <= 24'd0;
    end else begin
      state <= state_n;
      if (byte_valid && !cs_high) begin
        unique case (state)
          ST_CMD: begin
            cmd     <= byte_rx;
            arg_cnt <= 2'd0;
            args    <= 24'd0;
          end
          ST_ARGS: begin
            args    <= {args[15:0], byte_rx};
            arg_cnt <= arg_cnt + 2'd1;
            if (last_arg) len <= len_full;
          end
          ST_DATA: len <= len - 24'd1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overlay       <= 1'b0;
      color         <= 15'd0;
      overlay_color <= 15'd0;
      rom_loading   <= 1'b0;
      rom_do        <= 8'd0;
      rom_do_valid  <= 1'b0;
      core_config   <= 32'd0;
    end else begin
      rom_do_valid <= rom_stb;
      if (rom_stb) rom_do <= byte_rx;
      if (commit) begin
        unique case (cmd)
          CMD_CFG:     core_config <= {args, byte_rx};
          CMD_OVL:     overlay     <= byte_rx[0];
          CMD_COLOR:   color       <= {args[6:0], byte_rx};
          CMD_LOADING: rom_loading <= byte_rx[0];
          default: ;
        endcase
      end
      overlay_color <= (overlay && (overlay_x[3] ^ overlay_y[3]))
                     ? color : 15'd0;
    end
  end

  logic [7:0]    q [4];
  logic [2:0]    q_cnt;
  logic [1:0]    q_rd;
  logic [TW-1:0] tmo;
  logic          fresh;
  logic          load_id;
  logic          load_joy;

  assign load_id  = commit && cmd == CMD_ID;
  assign load_joy = commit && cmd == CMD_JOY;
  assign head     = (q_cnt != 3'd0) ? q[q_rd] : 8'd0;

  // fresh blocks the pop at the end of the loading transaction
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q     <= '{default: 8'd0};
      q_cnt <= 3'd0;
      q_rd  <= 2'd0;
      tmo   <= '0;
      fresh <= 1'b0;
    end else begin
      if (cs_high) fresh <= 1'b0;
      if (load_id || load_joy) begin
        q[0]  <= load_id ? ID_M : {4'h0, joy1[11:8]};
        q[1]  <= load_id ? ID_C : joy1[7:0];
        q[2]  <= load_id ? id_digit(CORE_ID) : {4'h0, joy2[11:8]};
        q[3]  <= load_id ? ID_END : joy2[7:0];
        q_cnt <= 3'd4;
        q_rd  <= 2'd0;
        tmo   <= '0;
        fresh <= 1'b1;
      end else if (tx_done && !fresh && q_cnt != 3'd0) begin
        q_cnt <= q_cnt - 3'd1;
        q_rd  <= q_rd + 2'd1;
        tmo   <= '0;
      end else if (q_cnt != 3'd0) begin
        if (tmo == TW'(TMO - 1)) q_cnt <= 3'd0;
        else tmo <= tmo + 1'b1;
      end
    end
  end

  logic unused_xy;
  assign unused_xy = ^{overlay_x[8:4], overlay_x[2:0],
                       overlay_y[7:4], overlay_y[2:0]};

endmodule

// File: tb/tb_sys.sv
// Self-checking bench for sys: SPI master tasks, response
// scoreboard, ROM strobe monitor and an overlay vector table.
module tb_sys;

  logic        clk;
  logic        resetn;
  logic        overlay;
  logic [8:0]  overlay_x;
  logic [7:0]  overlay_y;
  logic [14:0] overlay_color;
  logic [11:0] joy1;
  logic [11:0] joy2;
  logic        rom_loading;
  logic [7:0]  rom_do;
  logic        rom_do_valid;
  logic [31:0] core_config;

  sys_if spi ();

  sys #(.FREQ(2_000_000), .CORE_ID(1)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .overlay       (overlay),
    .overlay_x     (overlay_x),
    .overlay_y     (overlay_y),
    .overlay_color (overlay_color),
    .joy1          (joy1),
    .joy2          (joy2),
    .rom_loading   (rom_loading),
    .rom_do        (rom_do),
    .rom_do_valid  (rom_do_valid),
    .core_config   (core_config),
    .sspi_cs       (spi.cs),
    .sspi_clk      (spi.sclk),
    .sspi_mosi     (spi.mosi),
    .sspi_miso     (spi.miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int rom_cnt = 0;
  logic prev_v = 1'b0;
  logic [7:0] sb[$];
  logic [7:0] exp_rom[$];
  logic [7:0] pkt[$];

  typedef struct {
    logic [7:0]  ovl;
    logic [8:0]  x;
    logic [7:0]  y;
    logic        exp_o;
    logic [14:0] exp_c;
  } ovl_vec_t;

  typedef struct {
    logic [11:0] j1;
    logic [11:0] j2;
    logic [31:0] exp;
  } joy_vec_t;

  ovl_vec_t ov [5];
  joy_vec_t jv [2];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] b, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      spi.mosi = b[i];
      #50;
      r[i] = spi.miso;
      spi.sclk = 1'b1;
      #50;
      spi.sclk = 1'b0;
    end
  endtask

  task automatic send();
    logic [7:0] r;
    spi.cs = 1'b0;
    #50;
    foreach (pkt[i]) xfer(pkt[i], r);
    #50;
    spi.cs = 1'b1;
    #100;
    pkt.delete();
  endtask

  task automatic rd(input string nm);
    logic [7:0] r;
    logic [7:0] e;
    spi.cs = 1'b0;
    #50;
    xfer(8'h00, r);
    #50;
    spi.cs = 1'b1;
    #100;
    if (sb.size() == 0) begin
      chk({nm, "_no_expect"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk(nm, {24'd0, r}, {24'd0, e});
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_overlay"}, {31'd0, overlay}, 32'd0);
    chk({nm, "_color"}, {17'd0, overlay_color}, 32'd0);
    chk({nm, "_loading"}, {31'd0, rom_loading}, 32'd0);
    chk({nm, "_rom_do"}, {24'd0, rom_do}, 32'd0);
    chk({nm, "_rom_valid"}, {31'd0, rom_do_valid}, 32'd0);
    chk({nm, "_config"}, core_config, 32'd0);
    chk({nm, "_miso"}, {31'd0, spi.miso}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (resetn && rom_do_valid) begin
      rom_cnt++;
      chk("rom_pulse_width", {31'd0, prev_v}, 32'd0);
      if (exp_rom.size() == 0)
        chk("rom_unexpected", {24'd0, rom_do}, 32'hFFFF_FFFF);
      else
        chk("rom_do", {24'd0, rom_do}, {24'd0, exp_rom.pop_front()});
    end
    prev_v = rom_do_valid;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    ov[0] = '{8'h01, 9'd8, 8'd0, 1'b1, 15'h7FFF};
    ov[1] = '{8'h01, 9'd8, 8'd8, 1'b1, 15'h0000};
    ov[2] = '{8'h01, 9'd0, 8'd8, 1'b1, 15'h7FFF};
    ov[3] = '{8'h01, 9'd7, 8'd7, 1'b1, 15'h0000};
    ov[4] = '{8'h00, 9'd8, 8'd0, 1'b0, 15'h0000};
    jv[0] = '{12'hABC, 12'h123, 32'h0ABC_0123};
    jv[1] = '{12'hFFF, 12'h000, 32'h0FFF_0000};

    resetn = 1'b0;
    spi.cs = 1'b1;
    spi.sclk = 1'b0;
    spi.mosi = 1'b0;
    overlay_x = 9'd0;
    overlay_y = 8'd0;
    joy1 = 12'd0;
    joy2 = 12'd0;
    repeat (4) @(negedge clk);
    chk_reset_outputs("reset");
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    pkt = '{8'h01, 8'h00};
    send();
    sb.push_back(8'h4D);
    sb.push_back(8'h43);
    sb.push_back(8'h31);
    sb.push_back(8'h00);
    for (int i = 0; i < 4; i++) rd("id_byte");
    sb.push_back(8'h00);
    rd("id_empty");

    pkt = '{8'h02, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    send();
    chk("cfg_a5", core_config, 32'hA5A5_A5A5);
    pkt = '{8'h02, 8'h12, 8'h34};
    send();
    chk("cfg_abort", core_config, 32'hA5A5_A5A5);
    pkt = '{8'h02, 8'h5A, 8'h0F, 8'hF0, 8'hC3};
    send();
    chk("cfg_5a", core_config, 32'h5A0F_F0C3);

    pkt = '{8'h06, 8'h01};
    send();
    chk("loading_on", {31'd0, rom_loading}, 32'd1);
    pkt = '{8'h06, 8'h00};
    send();
    chk("loading_off", {31'd0, rom_loading}, 32'd0);

    base = rom_cnt;
    exp_rom.push_back(8'h11);
    exp_rom.push_back(8'h22);
    exp_rom.push_back(8'h33);
    pkt = '{8'h07, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
    send();
    chk("rom_pulses_3", rom_cnt - base, 32'd3);
    base = rom_cnt;
    pkt = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h55};
    send();
    chk("rom_pulses_0", rom_cnt - base, 32'd0);

    foreach (jv[i]) begin
      joy1 = jv[i].j1;
      joy2 = jv[i].j2;
      pkt = '{8'h05, 8'h00};
      send();
      joy1 = 12'h555;
      joy2 = 12'hAAA;
      for (int k = 3; k >= 0; k--) sb.push_back(jv[i].exp[k*8 +: 8]);
      for (int k = 0; k < 4; k++) rd("joy_byte");
    end

    pkt = '{8'h04, 8'h7F, 8'hFF};
    send();
    foreach (ov[i]) begin
      pkt = '{8'h03, ov[i].ovl};
      send();
      overlay_x = ov[i].x;
      overlay_y = ov[i].y;
      repeat (3) @(negedge clk);
      chk("ovl_enable", {31'd0, overlay}, {31'd0, ov[i].exp_o});
      chk("ovl_color", {17'd0, overlay_color}, {17'd0, ov[i].exp_c});
    end

    pkt = '{8'h01, 8'h00};
    send();
    repeat (19000) @(negedge clk);
    sb.push_back(8'h4D);
    rd("tmo_before");
    repeat (20100) @(negedge clk);
    sb.push_back(8'h00);
    rd("tmo_after");

    pkt = '{8'h03, 8'h01};
    send();
    pkt = '{8'h06, 8'h01};
    send();
    chk("pre_rst_overlay", {31'd0, overlay}, 32'd1);
    chk("pre_rst_loading", {31'd0, rom_loading}, 32'd1);
    exp_rom.push_back(8'hAA);
    begin
      logic [7:0] r;
      spi.cs = 1'b0;
      #50;
      xfer(8'h07, r);
      xfer(8'h00, r);
      xfer(8'h00, r);
      xfer(8'h05, r);
      xfer(8'hAA, r);
      #50;
    end
    @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("midrst");
    spi.cs = 1'b1;
    spi.mosi = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    chk_reset_outputs("postrst");

    pkt = '{8'h01, 8'h00};
    send();
    sb.push_back(8'h4D);
    sb.push_back(8'h43);
    sb.push_back(8'h31);
    sb.push_back(8'h00);
    for (int i = 0; i < 4; i++) rd("id_after_rst");

    chk("rom_left", exp_rom.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
